fft_seq_ctrl: RTL and testbench
===============================

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning FFT points (power of two, >= 4).
REQ-002 SHALL have parameter word_size, default 16, meaning bits per real/imag part; passed through to the RAM and butterfly, with no width effect here.
REQ-003 SHALL have local parameter STAGES = $clog2(N).
REQ-004 SHALL have port clk  in  1  the single clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to run a full in-place FFT.
REQ-007 SHALL have port busy  out  1  high from the first cycle after an accepted start until the cycle after DONE.
REQ-008 SHALL have port done  out  1  one-cycle pulse on completion.
REQ-009 SHALL have port ram_address1, ram_address2  out  $clog2(N)  butterfly pair addresses to the complex RAM.
REQ-010 SHALL have port ram_read_en, ram_wr_en, ram_sel  out  1  RAM read, write and select strobes.
REQ-011 SHALL have port ram_o_valid, ram_wr_complete  in  1  RAM read and write acknowledges.
REQ-012 SHALL have port bf_start  out  1  one-cycle pulse telling the butterfly that RAM outputs hold a valid pair.
REQ-013 SHALL have port bf_done  in  1  butterfly result valid, to be written back.
REQ-014 SHALL have port twiddle_idx  out  $clog2(N)-1  twiddle ROM index k for W_N^k.

Function
REQ-015 SHALL be a registered-output FSM with states IDLE, READ, WAIT_RD, BFLY, WRITE, WAIT_WR, NEXT, DONE.
REQ-016 SHALL keep counters stage s (0..STAGES-1) and butterfly b (0..N/2-1).
REQ-017 SHALL compute span = 2^s, pos = b & (span-1), addr1 = ((b >> s) << (s+1)) | pos, addr2 = addr1 + span, and twiddle_idx = pos << (STAGES-1-s), all truncated to port width.
REQ-018 SHALL, in IDLE with start=1, clear s and b, set busy, and go to READ; start SHALL be ignored in every other state.
REQ-019 SHALL, in READ, drive ram_read_en=1 and ram_sel=1 for exactly one cycle, then go to WAIT_RD.
REQ-020 SHALL, in WAIT_RD, hold until ram_o_valid=1, then go to BFLY with bf_start=1 during the first BFLY cycle only.
REQ-021 SHALL, in BFLY, ignore bf_done during the bf_start cycle and go to WRITE on the first later cycle with bf_done=1.
REQ-022 SHALL, in WRITE, drive ram_wr_en=1 and ram_sel=1 for exactly one cycle, then go to WAIT_WR.
REQ-023 SHALL, in WAIT_WR, hold until ram_wr_complete=1, then go to NEXT.
REQ-024 SHALL, in NEXT, take one of three transitions:
- if b < N/2-1: b++ and go to READ;
- else if s < STAGES-1: b=0, s++ and go to READ;
- else go to DONE.
REQ-025 SHALL, in DONE, pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-026 SHALL hold ram_address1/2 and twiddle_idx stable from READ through WAIT_WR of each butterfly.
REQ-027 SHALL never assert ram_read_en and ram_wr_en in the same cycle, and SHALL keep ram_sel=0 outside READ and WRITE.
REQ-028 SHALL, with single-cycle responders, take exactly 7 cycles per butterfly (READ, WAIT_RD, 2xBFLY, WRITE, WAIT_WR, NEXT) and issue (N/2)*STAGES butterflies per run.
REQ-029 SHALL wait indefinitely on a missing acknowledge, with no timeout.

Reset
REQ-030 SHALL, on rst=1 at a clock edge (including mid-run), enter IDLE and clear s, b, busy, done, bf_start, ram_read_en, ram_wr_en, ram_sel, ram_address1/2 and twiddle_idx to 0.
REQ-031 SHALL give rst priority over start in the same cycle.

Verification
REQ-032 SHALL be verified with N=8 and a single-cycle RAM and butterfly model: pulse start; the first butterfly gives addr 0/1, tw 0; the stage-1 butterfly b=1 gives addr 1/3, tw 2; the stage-2 butterfly b=3 gives addr 3/7, tw 3; exactly 12 read and 12 write strobes occur; done pulses once, 84 cycles after READ is first entered.
REQ-033 SHALL be verified by pulsing start while busy: no restart occurs and the address sequence is unchanged.
REQ-034 SHALL be verified by delaying ram_o_valid 5 cycles and bf_done 3 cycles: addresses stay stable, and there are no extra strobes and no bf_start repeat.
REQ-035 SHALL be verified by asserting rst during the WRITE of stage 1: the next cycle has all outputs 0 and state IDLE; a new start then restarts at addr 0/1.
REQ-036 SHALL be verified by asserting start and rst in the same cycle: busy stays 0.
REQ-037 SHALL be verified across a full N=32 run: 80 butterflies, every address pair differs by 2^s, and ram_read_en and ram_wr_en never overlap.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fft_seq_ctrl                                               |
// | Purpose : Sequencer for an in-place radix-2 FFT. Walks every stage   |
// |           and butterfly, issues RAM read/write strobes, starts the   |
// |           butterfly unit and presents pair addresses and twiddle     |
// |           index.                                                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fft_seq_ctrl #(
  parameter int N         = 32,
  parameter int word_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] ram_address1,
  output logic [$clog2(N)-1:0] ram_address2,
  output logic                 ram_read_en,
  output logic                 ram_wr_en,
  output logic                 ram_sel,
  input  logic                 ram_o_valid,
  input  logic                 ram_wr_complete,
  output logic                 bf_start,
  input  logic                 bf_done,
  output logic [$clog2(N)-2:0] twiddle_idx
);

  localparam int STAGES = $clog2(N);
  localparam int AW     = STAGES;
  localparam int TW     = STAGES - 1;
  localparam logic [AW-1:0] B_LAST = AW'(N / 2 - 1);
  localparam logic [AW-1:0] S_LAST = AW'(STAGES - 1);

  // word_size only travels to the RAM and butterfly; here it is sanity-checked.
  generate
    if (N < 4 || (N & (N - 1)) != 0 || word_size < 1) begin : g_param_check
      $error("fft_seq_ctrl: N must be a power of two >= 4 and word_size positive");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT_RD = 3'd2,
    BFLY    = 3'd3,
    WRITE   = 3'd4,
    WAIT_WR = 3'd5,
    NEXT    = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   s, s_n;
  logic [AW-1:0]   b, b_n;
  logic [AW-1:0]   span_n, pos_n, addr1_n, addr2_n;
  logic [TW-1:0]   tw_n;
  logic            busy_n, done_n, rd_n, wr_n, sel_n, bfs_n;

  // Next-state and counter update; bf_done is ignored in the bf_start cycle.
  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          s_n     = '0;
          b_n     = '0;
        end
      end
      READ:    state_n = WAIT_RD;
      WAIT_RD: if (ram_o_valid) state_n = BFLY;
      BFLY:    if (bf_done && !bf_start) state_n = WRITE;
      WRITE:   state_n = WAIT_WR;
      WAIT_WR: if (ram_wr_complete) state_n = NEXT;
      NEXT: begin
        if (b < B_LAST) begin
          b_n     = b + AW'(1);
          state_n = READ;
        end else if (s < S_LAST) begin
          b_n     = '0;
          s_n     = s + AW'(1);
          state_n = READ;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a register.
  always_comb begin
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    rd_n   = (state_n == READ);
    wr_n   = (state_n == WRITE);
    sel_n  = rd_n | wr_n;
    bfs_n  = (state_n == BFLY) && (state != BFLY);
  end

  // Butterfly pair addresses and twiddle index for the upcoming (s, b).
  always_comb begin
    span_n  = AW'(1) << s_n;
    pos_n   = b_n & (span_n - AW'(1));
    addr1_n = ((b_n >> s_n) << (s_n + AW'(1))) | pos_n;
    addr2_n = addr1_n + span_n;
    tw_n    = TW'(pos_n << (S_LAST - s_n));
  end

  // State, counters and registered outputs; addresses latch only on READ entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      b            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ram_read_en  <= 1'b0;
      ram_wr_en    <= 1'b0;
      ram_sel      <= 1'b0;
      bf_start     <= 1'b0;
      ram_address1 <= '0;
      ram_address2 <= '0;
      twiddle_idx  <= '0;
    end else begin
      state       <= state_n;
      s           <= s_n;
      b           <= b_n;
      busy        <= busy_n;
      done        <= done_n;
      ram_read_en <= rd_n;
      ram_wr_en   <= wr_n;
      ram_sel     <= sel_n;
      bf_start    <= bfs_n;
      if (state_n == READ && state != READ) begin
        ram_address1 <= addr1_n;
        ram_address2 <= addr2_n;
        twiddle_idx  <= tw_n;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fft_seq_ctrl                                            |
// | Purpose : Scoreboard bench for fft_seq_ctrl at N=8 and N=32 with     |
// |           delay-configurable RAM and butterfly responders.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fft_seq_ctrl;

  typedef struct {
    int a1;
    int a2;
    int tw;
  } bfly_t;

  logic clk;
  int   cyc;
  int   tests;
  int   fails;
  bit   fin [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int NN  = (gi == 0) ? 8 : 32;
    localparam int ST  = $clog2(NN);
    localparam int NBF = (NN / 2) * ST;

    logic          rst, start, ram_o_valid, ram_wr_complete, bf_done;
    logic          busy, done, ram_read_en, ram_wr_en, ram_sel, bf_start;
    logic [ST-1:0] ram_address1, ram_address2;
    logic [ST-2:0] twiddle_idx;

    fft_seq_ctrl #(.N(NN), .word_size(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .ram_address1   (ram_address1),
      .ram_address2   (ram_address2),
      .ram_read_en    (ram_read_en),
      .ram_wr_en      (ram_wr_en),
      .ram_sel        (ram_sel),
      .ram_o_valid    (ram_o_valid),
      .ram_wr_complete(ram_wr_complete),
      .bf_start       (bf_start),
      .bf_done        (bf_done),
      .twiddle_idx    (twiddle_idx)
    );

    bfly_t expq[$];
    int rd_d = 1, bf_d = 1, wr_d = 1;
    bit noise = 0;
    int n_rd, n_wr, n_bfs, n_done, first_rd, done_cyc;

    function automatic string nm(input string t);
      return $sformatf("N%0d_%s", NN, t);
    endfunction

    // Reference: stage s pairs every index i with bit s clear against i+2^s,
    // in ascending i; twiddle exponent is (i mod 2^s) scaled to N points.
    task automatic push_model();
      for (int s = 0; s < ST; s++) begin
        int span;
        span = 1 << s;
        for (int i = 0; i < NN; i++)
          if (((i / span) % 2) == 0)
            expq.push_back('{i, i + span, (i % span) * (NN / (2 * span))});
      end
    endtask

    // Responders and monitor share one process so their ordering is fixed.
    initial begin
      int rd_cnt, bf_cnt, wr_cnt, bfs_this, cur_a1, cur_a2, cur_tw;
      bit in_bf, bf_real;
      bfly_t e;
      rd_cnt = 0; bf_cnt = 0; wr_cnt = 0; bfs_this = 0;
      cur_a1 = 0; cur_a2 = 0; cur_tw = 0; in_bf = 0; bf_real = 0;
      ram_o_valid = 0; ram_wr_complete = 0; bf_done = 0;
      forever begin
        @(posedge clk); #1;
        if (rst) begin
          in_bf = 0;
        end else begin
          if (ram_read_en || ram_wr_en) begin
            check(nm("strobe_excl"), ram_read_en & ram_wr_en, 0);
            check(nm("sel_on_strobe"), ram_sel, 1);
          end else if (ram_sel) begin
            check(nm("sel_idle"), ram_sel, 0);
          end
          if (ram_read_en) begin
            if (expq.size() == 0) begin
              check(nm("unexpected_read"), 1, 0);
            end else begin
              e = expq.pop_front();
              check(nm("addr1"), ram_address1, e.a1);
              check(nm("addr2"), ram_address2, e.a2);
              check(nm("twiddle"), twiddle_idx, e.tw);
            end
            check(nm("busy_in_run"), busy, 1);
            if (n_rd == 0) first_rd = cyc;
            n_rd++;
            in_bf = 1; bfs_this = 0;
            cur_a1 = ram_address1; cur_a2 = ram_address2; cur_tw = twiddle_idx;
          end else if (in_bf) begin
            check(nm("addr_stable"), {ram_address1, ram_address2, twiddle_idx},
                  {cur_a1[ST-1:0], cur_a2[ST-1:0], cur_tw[ST-2:0]});
          end
          if (bf_start) begin
            n_bfs++; bfs_this++;
            check(nm("bf_start_once"), bfs_this, 1);
          end
          if (ram_wr_en) begin
            check(nm("wr_after_bf_done"), bf_real, 1);
            n_wr++;
          end
          if (ram_wr_complete) in_bf = 0;
          if (done) begin
            n_done++;
            done_cyc = cyc;
          end
        end
        ram_o_valid = 0; ram_wr_complete = 0; bf_done = 0; bf_real = 0;
        if (rst) begin
          rd_cnt = 0; bf_cnt = 0; wr_cnt = 0;
        end else begin
          if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) ram_o_valid = 1; end
          if (bf_cnt > 0) begin bf_cnt--; if (bf_cnt == 0) begin bf_done = 1; bf_real = 1; end end
          if (wr_cnt > 0) begin wr_cnt--; if (wr_cnt == 0) ram_wr_complete = 1; end
          if (ram_read_en) rd_cnt = rd_d;
          if (bf_start) begin bf_cnt = bf_d; if (noise) bf_done = 1; end
          if (ram_wr_en) wr_cnt = wr_d;
        end
      end
    end

    task automatic clear_stats();
      n_rd = 0; n_wr = 0; n_bfs = 0; n_done = 0; first_rd = 0; done_cyc = 0;
    endtask

    task automatic set_delays(input int r, input int bfl, input int w, input bit nz);
      rd_d = r; bf_d = bfl; wr_d = w; noise = nz;
    endtask

    task automatic kick();
      clear_stats();
      expq.delete();
      push_model();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
    endtask

    task automatic finish_run(input bit extra);
      int budget, k;
      budget = NBF * (4 + rd_d + bf_d + wr_d) + 50;
      k = 0;
      while (n_done == 0 && k < budget) begin
        @(negedge clk);
        start = extra && busy && ($urandom_range(0, 15) == 0);
        k++;
      end
      start = 0;
      check(nm("done_seen"), n_done, 1);
      repeat (4) @(negedge clk);
      check(nm("done_once"), n_done, 1);
      check(nm("read_strobes"), n_rd, NBF);
      check(nm("write_strobes"), n_wr, NBF);
      check(nm("bf_starts"), n_bfs, NBF);
      check(nm("done_latency"), done_cyc - first_rd, NBF * (4 + rd_d + bf_d + wr_d));
      check(nm("busy_after"), busy, 0);
      check(nm("queue_empty"), expq.size(), 0);
    endtask

    // Scenario sequence for this instance.
    initial begin
      int k;
      rst = 1; start = 0;
      clear_stats();
      repeat (3) @(negedge clk);
      check(nm("reset_outputs"), {busy, done, ram_read_en, ram_wr_en, ram_sel, bf_start,
            ram_address1, ram_address2, twiddle_idx}, 0);
      rst = 0;

      set_delays(1, 1, 1, 0);
      kick(); finish_run(0);

      kick(); finish_run(1);

      set_delays(5, 3, $urandom_range(1, 3), 1);
      kick(); finish_run(0);

      set_delays(1, 1, 1, 0);
      kick();
      k = 0;
      while (!(ram_wr_en && n_wr == NN / 2 + 2) && k < NBF * 7 + 50) begin
        @(negedge clk); k++;
      end
      check(nm("reached_stage1_write"), ram_wr_en, 1);
      rst = 1;
      @(negedge clk);
      check(nm("midrun_reset_outputs"), {busy, done, ram_read_en, ram_wr_en, ram_sel, bf_start,
            ram_address1, ram_address2, twiddle_idx}, 0);
      rst = 0;
      expq.delete();
      repeat (3) @(negedge clk);
      check(nm("idle_after_reset"), busy, 0);
      kick(); finish_run(0);

      clear_stats();
      rst = 1; start = 1;
      @(negedge clk);
      rst = 0; start = 0;
      repeat (5) @(negedge clk);
      check(nm("rst_beats_start_busy"), busy, 0);
      check(nm("rst_beats_start_reads"), n_rd, 0);

      repeat (2) begin
        set_delays($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                   1'($urandom_range(0, 1)));
        kick(); finish_run(1'($urandom_range(0, 1)));
      end
      fin[gi] = 1;
    end
  end

  initial begin
    wait (fin[0] && fin[1]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
